fifo_access_sched: RTL
======================

FIFO_ACCESS_SCHED -- requirements
Module: fifo_access_sched

Interface
REQ-001 Parameter DATA_W, default 16, FIFO word width.
REQ-002 Parameter DEPTH, default 16, FIFO capacity in words.
REQ-003 Parameter AF_LEVEL, default 12, almost-full threshold in words.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low (0 = reset).
REQ-006 wr_req  in  2  per-producer write request, held until granted.
REQ-007 wr_data0, wr_data1  in  DATA_W each  producer 0/1 write data, stable while wr_req bit high.
REQ-008 wr_gnt  out  2  one-hot combinational write grant; write accepted at edge where bit high.
REQ-009 rd_req  in  1  consumer read request.
REQ-010 rd_gnt  out  1  combinational read grant.
REQ-011 rd_valid  out  1  registered; high one cycle after a non-flush read grant.
REQ-012 rd_data  out  DATA_W  equals fifo_data_out while rd_valid high.
REQ-013 flush  in  1  single-cycle pulse requesting FIFO drain.
REQ-014 busy_flush  out  1  high while in FLUSH state.
REQ-015 level  out  $clog2(DEPTH)+1  registered occupancy.
REQ-016 almost_full  out  1  level >= AF_LEVEL.
REQ-017 fifo_write_en, fifo_read_en  out  1 each; fifo_data_in  out  DATA_W  FIFO port drive.
REQ-018 fifo_full, fifo_empty  in  1 each; fifo_data_out  in  DATA_W  FIFO status/data.
REQ-019 fifo_rst  out  1  active-high FIFO reset, equals NOT reset.

Function
REQ-020 At most one FIFO access per cycle: fifo_write_en and fifo_read_en never both high.
REQ-021 Eligibility in RUN: W0 = wr_req[0] & !fifo_full; W1 = wr_req[1] & !fifo_full; R = rd_req & !fifo_empty.
REQ-022 Three-slot round-robin (W0, W1, R); highest priority is slot after last granted; pointer updates only on a grant.
REQ-023 Pointer after reset gives priority order W0, W1, R.
REQ-024 Granted write: fifo_write_en=1, fifo_data_in = selected producer data, same cycle; otherwise fifo_data_in = 0.
REQ-025 Granted read: fifo_read_en=1; rd_valid=1 next cycle with rd_data = fifo_data_out (1-cycle latency).
REQ-026 No grant to an ineligible slot; full blocks writes, empty blocks reads, without error.
REQ-027 States RUN, FLUSH; RUN -> FLUSH on flush=1; FLUSH -> RUN on the cycle fifo_empty=1 and no read issued.
REQ-028 In FLUSH: wr_gnt=0, rd_gnt=0, fifo_read_en = !fifo_empty every cycle, rd_valid stays 0 (data discarded).
REQ-029 flush=1 while in FLUSH is ignored; flush with FIFO already empty gives one FLUSH cycle then RUN.
REQ-030 Requests arriving in the flush cycle are not granted that cycle.
REQ-031 level +1 per write, -1 per read, else holds; never exceeds DEPTH nor below 0.
REQ-032 level==0 iff fifo_empty and level==DEPTH iff fifo_full (asserted invariant).

Reset
REQ-033 While reset=0: state RUN, pointer W0, level 0, rd_valid 0, busy_flush 0, all grants and fifo enables 0, fifo_rst 1.
REQ-034 Reset mid-transfer abandons in-flight rd_valid; first cycle after release arbitrates normally.

Structure
REQ-035 Package link_pkg holds DATA_W default, DEPTH default, slot enum {SLOT_W0, SLOT_W1, SLOT_R}, state enum {ST_RUN, ST_FLUSH}.
REQ-036 Sub-module rr_arb3 (3-request round-robin, one-hot grant, pointer register); FSM, level counter and muxing stay top level.

Verification
REQ-037 Post-reset, wr_req=2'b11 held, empty FIFO -> grants alternate W0,W1,W0,W1; level 1,2,3,4.
REQ-038 16 writes 0x0001..0x0010 then wr_req=1 -> wr_gnt=0, level=16, almost_full=1; rd_req -> rd_valid next cycle with 0x0001.
REQ-039 wr_req=2'b01 and rd_req=1 continuously, FIFO holding 3 words -> grants rotate W0,R,W0,R; never both enables high.
REQ-040 FIFO with 5 words, flush pulse -> busy_flush 1 for 6 cycles, 5 reads, rd_valid stays 0, level 0, back to RUN.
REQ-041 Reset asserted the cycle after a read grant -> rd_valid 0, level 0, fifo_rst 1; after release W0 granted first.
REQ-042 rd_req=1 on empty FIFO for 10 cycles -> rd_gnt=0, fifo_read_en=0, rd_valid=0 throughout.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared defaults, slot and state types for fifo_access_sched
package link_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int DEPTH_DEF    = 16;
    localparam int AF_LEVEL_DEF = 12;

    // Arbitration slots in round-robin order: producer 0, producer 1, consumer.
    typedef enum logic [1:0] {
        SLOT_W0 = 2'd0,
        SLOT_W1 = 2'd1,
        SLOT_R  = 2'd2
    } slot_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Slot that becomes highest priority after slot s has been granted.
    function automatic slot_e slot_after(input slot_e s);
        case (s)
            SLOT_W0: return SLOT_W1;
            SLOT_W1: return SLOT_R;
            default: return SLOT_W0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_access_sched_if.sv
// rtl/fifo_access_sched_if.sv - producer/consumer/flush/FIFO-port bundle for fifo_access_sched
//
// Ports (slave = scheduler view):
//   wr_req[1:0], wr_data0, wr_data1 -> write requests and data from two producers
//   wr_gnt[1:0]                     <- one-hot combinational write grant
//   rd_req / rd_gnt                 -> consumer read request / combinational grant
//   rd_valid, rd_data               <- read data, one cycle after a read grant
//   flush / busy_flush              -> drain request pulse / draining indication
//   level, almost_full              <- registered occupancy and threshold flag
//   fifo_write_en, fifo_read_en, fifo_data_in, fifo_rst <- drive of the external FIFO
//   fifo_full, fifo_empty, fifo_data_out                -> status/data from the external FIFO
interface fifo_access_sched_if
    import link_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [1:0]        wr_req;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;
    logic              rd_req;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              flush;
    logic              busy_flush;
    logic [LVL_W-1:0]  level;
    logic              almost_full;
    logic              fifo_write_en;
    logic              fifo_read_en;
    logic [DATA_W-1:0] fifo_data_in;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_rst;

    modport master (
        output wr_req, wr_data0, wr_data1, rd_req, flush,
        output fifo_full, fifo_empty, fifo_data_out,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, busy_flush, level, almost_full,
        input  fifo_write_en, fifo_read_en, fifo_data_in, fifo_rst
    );

    modport slave (
        input  wr_req, wr_data0, wr_data1, rd_req, flush,
        input  fifo_full, fifo_empty, fifo_data_out,
        output wr_gnt, rd_gnt, rd_valid, rd_data, busy_flush, level, almost_full,
        output fifo_write_en, fifo_read_en, fifo_data_in, fifo_rst
    );

endinterface

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - three-request round-robin arbiter with one-hot grant
//
// Ports:
//   clk, reset  clock and synchronous active-low reset
//   req[2:0]    requests, bit index = slot (W0, W1, R)
//   gnt[2:0]    one-hot combinational grant; the priority pointer moves only on a grant
module rr_arb3
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    slot_e      prio;       // slot currently holding highest priority
    slot_e      gnt_slot;
    logic [2:0] rot;        // requests rotated so that bit 0 is the priority slot
    logic [2:0] rot_gnt;

    // Rotate, take the lowest set bit, rotate back.
    always_comb begin
        rot = req;
        case (prio)
            SLOT_W1: rot = {req[0], req[2:1]};
            SLOT_R:  rot = {req[1:0], req[2]};
            default: rot = req;
        endcase
    end

    always_comb begin
        rot_gnt = 3'b000;
        if (rot[0]) begin
            rot_gnt = 3'b001;
        end else if (rot[1]) begin
            rot_gnt = 3'b010;
        end else if (rot[2]) begin
            rot_gnt = 3'b100;
        end
    end

    always_comb begin
        gnt = rot_gnt;
        case (prio)
            SLOT_W1: gnt = {rot_gnt[1:0], rot_gnt[2]};
            SLOT_R:  gnt = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
            default: gnt = rot_gnt;
        endcase
    end

    always_comb begin
        gnt_slot = SLOT_W0;
        if (gnt[1]) begin
            gnt_slot = SLOT_W1;
        end else if (gnt[2]) begin
            gnt_slot = SLOT_R;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio <= SLOT_W0;
        end else if (|gnt) begin
            prio <= slot_after(gnt_slot);
        end
    end

endmodule

// File: rtl/fifo_access_sched.sv
// rtl/fifo_access_sched.sv - single-port FIFO access scheduler for two producers, one consumer and flush
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (0 = reset)
//   bus    fifo_access_sched_if.slave: request/grant handshakes, read data, flush
//          control, occupancy and the drive/status of the external FIFO
module fifo_access_sched
    import link_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_access_sched_if.slave   bus
);

    localparam int               LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF  = LVL_W'(AF_LEVEL);

    state_e           state;
    state_e           state_nxt;
    logic             arb_open;
    logic [2:0]       elig;
    logic [2:0]       gnt;
    logic             flush_rd;
    logic             do_write;
    logic             do_read;
    logic [LVL_W-1:0] level_q;
    logic             rd_valid_q;

    // Arbitration only in RUN and never in the cycle a flush pulse arrives;
    // reset also closes it so no grant leaks out while held in reset.
    assign arb_open = reset && (state == ST_RUN) && !bus.flush;

    assign elig[0] = arb_open && bus.wr_req[0] && !bus.fifo_full;
    assign elig[1] = arb_open && bus.wr_req[1] && !bus.fifo_full;
    assign elig[2] = arb_open && bus.rd_req    && !bus.fifo_empty;

    rr_arb3 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .gnt   (gnt)
    );

    // Draining reads are issued every FLUSH cycle the FIFO still holds data.
    assign flush_rd = reset && (state == ST_FLUSH) && !bus.fifo_empty;

    assign do_write = gnt[0] || gnt[1];
    assign do_read  = gnt[2] || flush_rd;

    assign bus.wr_gnt        = gnt[1:0];
    assign bus.rd_gnt        = gnt[2];
    assign bus.fifo_write_en = do_write;
    assign bus.fifo_read_en  = do_read;
    assign bus.fifo_rst      = !reset;

    always_comb begin
        bus.fifo_data_in = '0;
        if (gnt[0]) begin
            bus.fifo_data_in = bus.wr_data0;
        end else if (gnt[1]) begin
            bus.fifo_data_in = bus.wr_data1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (bus.flush) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Leave on the first cycle with nothing left to discard.
                if (bus.fifo_empty) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            // Flush reads are discarded, so only arbitrated reads return data.
            rd_valid_q <= gnt[2];
            if (do_write && (level_q != LVL_MAX)) begin
                level_q <= level_q + 1'b1;
            end else if (do_read && (level_q != '0)) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.almost_full = (level_q >= LVL_AF);
    assign bus.busy_flush  = reset && (state == ST_FLUSH);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_valid_q ? bus.fifo_data_out : '0;

    // The occupancy count must track the FIFO's own flags exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(do_write && do_read));
            assert ((level_q == '0) == bus.fifo_empty);
            assert ((level_q == LVL_MAX) == bus.fifo_full);
        end
    end

endmodule
